// File: rtl/stack_engine.sv
// Hardware stack unit: owns SP, sequences PUSH/POP/CALL/RET against a RAM with a
// synchronous write and a registered (1-cycle) read, and tracks sticky bound errors.
module stack_engine #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 8'hFF,
    parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 8'hF0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    input  logic [DATA_WIDTH-1:0] i_ret_pc,
    input  logic                  i_sp_load,
    input  logic [ADDR_WIDTH-1:0] i_sp_value,
    input  logic                  i_err_clear,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_is_ret,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_ram_load,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic [ADDR_WIDTH-1:0] o_sp,
    output logic [ADDR_WIDTH-1:0] o_depth,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   sp;
    logic [ADDR_WIDTH-1:0]   sp_nxt;
    logic                    pend_ret;
    logic                    pend_empty;
    logic                    rd_issue;
    logic                    ovf_set;
    logic                    unf_set;
    logic                    full;
    logic                    empty;

    // Bounds are evaluated against SP as-is, even after an out-of-range SP load.
    assign full    = sp < STACK_LIMIT;
    assign empty   = sp == STACK_BASE;
    assign o_sp    = sp;
    assign o_depth = STACK_BASE - sp;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, command acceptance and RAM port drive
    always_comb begin
        state_nxt   = state;
        sp_nxt      = sp;
        o_cmd_ready = 1'b0;
        o_ram_load  = 1'b0;
        o_ram_addr  = sp;
        o_ram_data  = i_cmd_data;
        rd_issue    = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        case (state)
            IDLE: begin
                o_cmd_ready = !i_sp_load;
                if (i_cmd_valid && !i_sp_load) begin
                    if (!i_cmd_op[0]) begin
                        // PUSH (00) or CALL (10): write at SP, then decrement
                        o_ram_data = i_cmd_op[1] ? i_ret_pc : i_cmd_data;
                        if (full) begin
                            ovf_set = 1'b1;
                        end else begin
                            o_ram_load = 1'b1;
                            sp_nxt     = sp - ADDR_WIDTH'(1);
                        end
                    end else begin
                        // POP (01) or RET (11): top of stack lives at SP+1
                        o_ram_addr = sp + ADDR_WIDTH'(1);
                        rd_issue   = 1'b1;
                        state_nxt  = RD_WAIT;
                        if (empty) begin
                            unf_set = 1'b1;
                        end else begin
                            sp_nxt = sp + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            RD_WAIT: state_nxt = RD_DONE;
            RD_DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (i_sp_load) begin
            sp_nxt = i_sp_value;
        end
    end

    // Datapath registers: SP, read bookkeeping, response and sticky flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp           <= STACK_BASE;
            pend_ret     <= 1'b0;
            pend_empty   <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_is_ret <= 1'b0;
            o_rsp_data   <= '0;
            o_overflow   <= 1'b0;
            o_underflow  <= 1'b0;
        end else begin
            sp <= sp_nxt;
            if (rd_issue) begin
                pend_ret   <= i_cmd_op[1];
                pend_empty <= empty;
            end
            if (state == RD_WAIT) begin
                o_rsp_data <= pend_empty ? '0 : i_ram_data;
            end
            o_rsp_valid  <= (state == RD_WAIT);
            o_rsp_is_ret <= (state == RD_WAIT) && pend_ret;
            // A new error in the same cycle as a clear wins
            o_overflow   <= ovf_set | (o_overflow & !i_err_clear);
            o_underflow  <= unf_set | (o_underflow & !i_err_clear);
        end
    end

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed vector table, multi-cycle corner
// sequences, and random traffic checked against a queue-based stack model.
module tb_stack_engine;

    localparam logic [1:0] PUSH = 2'b00;
    localparam logic [1:0] POP  = 2'b01;
    localparam logic [1:0] CALL = 2'b10;
    localparam logic [1:0] RET  = 2'b11;
    localparam int unsigned CAP = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op = 2'b00;
    logic [15:0] i_cmd_data = '0;
    logic [15:0] i_ret_pc = '0;
    logic        i_sp_load = 1'b0;
    logic [7:0]  i_sp_value = '0;
    logic        i_err_clear = 1'b0;
    logic        o_rsp_valid;
    logic        o_rsp_is_ret;
    logic [15:0] o_rsp_data;
    logic        o_ram_load;
    logic [7:0]  o_ram_addr;
    logic [15:0] o_ram_data;
    logic [15:0] i_ram_data;
    logic [7:0]  o_sp;
    logic [7:0]  o_depth;
    logic        o_overflow;
    logic        o_underflow;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] mem [0:255];

    stack_engine dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data), .i_ret_pc(i_ret_pc),
        .i_sp_load(i_sp_load), .i_sp_value(i_sp_value), .i_err_clear(i_err_clear),
        .o_rsp_valid(o_rsp_valid), .o_rsp_is_ret(o_rsp_is_ret), .o_rsp_data(o_rsp_data),
        .o_ram_load(o_ram_load), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
        .i_ram_data(i_ram_data),
        .o_sp(o_sp), .o_depth(o_depth),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    // RAM: synchronous write, registered read
    always @(posedge i_clk) begin
        if (o_ram_load) mem[o_ram_addr] <= o_ram_data;
        i_ram_data <= mem[o_ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rst_sp", 32'(o_sp), 32'h00FF);
        chk("rst_depth", 32'(o_depth), 32'h0);
        chk("rst_flags", 32'({o_overflow, o_underflow, o_rsp_valid, o_rsp_is_ret}), 32'h0);
        chk("rst_rsp_data", 32'(o_rsp_data), 32'h0);
        chk("rst_ready", 32'(o_cmd_ready), 32'h1);
        chk("rst_ram_load", 32'(o_ram_load), 32'h0);
    endtask

    // Issue one command starting at posedge+1; returns at posedge+1 when the engine is idle again.
    task automatic do_cmd(input logic [1:0] op, input logic [15:0] d, input logic [15:0] pc,
                          input logic clr, output logic wload, output logic [7:0] waddr,
                          output logic [15:0] wdata, output logic [15:0] rdata, output logic rret);
        chk("cmd_ready", 32'(o_cmd_ready), 32'h1);
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_data = d; i_ret_pc = pc; i_err_clear = clr;
        #2;
        wload = o_ram_load; waddr = o_ram_addr; wdata = o_ram_data;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0; i_err_clear = 1'b0;
        rdata = '0; rret = 1'b0;
        if (op[0]) begin
            chk("rdwait_valid", 32'(o_rsp_valid), 32'h0);
            chk("rdwait_ready", 32'(o_cmd_ready), 32'h0);
            @(posedge i_clk); #1;
            chk("rsp_valid", 32'(o_rsp_valid), 32'h1);
            chk("rsp_ready", 32'(o_cmd_ready), 32'h0);
            rdata = o_rsp_data; rret = o_rsp_is_ret;
            @(posedge i_clk); #1;
            chk("rsp_pulse_end", 32'(o_rsp_valid), 32'h0);
            chk("ready_again", 32'(o_cmd_ready), 32'h1);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [15:0] d;
        logic [15:0] pc;
        logic [7:0]  sp;
        logic [15:0] rd;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic        wl, rr;
        logic [7:0]  wa;
        logic [15:0] wd, rd;
        bit          ok;
        logic [15:0] q[$];
        logic        ovf_m, unf_m;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        vecs[0] = '{PUSH, 16'h1234, 16'h0000, 8'hFE, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{PUSH, 16'hBEEF, 16'h0000, 8'hFD, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{POP,  16'h0000, 16'h0000, 8'hFE, 16'hBEEF, 1'b0, 1'b0};
        vecs[3] = '{CALL, 16'h7777, 16'h0042, 8'hFD, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{RET,  16'h0000, 16'h0000, 8'hFE, 16'h0042, 1'b0, 1'b0};
        vecs[5] = '{POP,  16'h0000, 16'h0000, 8'hFF, 16'h1234, 1'b0, 1'b0};
        vecs[6] = '{POP,  16'h0000, 16'h0000, 8'hFF, 16'h0000, 1'b0, 1'b1};

        i_rst = 1'b1;
        #12;
        do_reset();

        // Directed vector table
        foreach (vecs[k]) begin
            do_cmd(vecs[k].op, vecs[k].d, vecs[k].pc, 1'b0, wl, wa, wd, rd, rr);
            if (!vecs[k].op[0]) begin
                chk("vec_wload", 32'(wl), 32'h1);
                chk("vec_waddr", 32'(wa), 32'(vecs[k].sp + 8'd1));
                chk("vec_wdata", 32'(wd), 32'(vecs[k].op[1] ? vecs[k].pc : vecs[k].d));
            end else begin
                chk("vec_rdata", 32'(rd), 32'(vecs[k].rd));
                chk("vec_is_ret", 32'(rr), 32'(vecs[k].op[1]));
            end
            chk("vec_sp", 32'(o_sp), 32'(vecs[k].sp));
            chk("vec_depth", 32'(o_depth), 32'(8'hFF - vecs[k].sp));
            chk("vec_ovf", 32'(o_overflow), 32'(vecs[k].ovf));
            chk("vec_unf", 32'(o_underflow), 32'(vecs[k].unf));
        end
        chk("mem_ff", 32'(mem[8'hFF]), 32'h1234);
        chk("mem_fe", 32'(mem[8'hFE]), 32'h0042);

        // Fill to capacity, then one more push overflows without writing
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_cmd(PUSH, 16'(16'hA000 + i), 16'h0, 1'b0, wl, wa, wd, rd, rr);
            chk("fill_wload", 32'(wl), 32'h1);
        end
        chk("fill_sp", 32'(o_sp), 32'h00EF);
        chk("fill_ovf", 32'(o_overflow), 32'h0);
        do_cmd(PUSH, 16'hDEAD, 16'h0, 1'b0, wl, wa, wd, rd, rr);
        chk("ovf_no_write", 32'(wl), 32'h0);
        chk("ovf_sp", 32'(o_sp), 32'h00EF);
        chk("ovf_set", 32'(o_overflow), 32'h1);
        chk("ovf_mem_ef", 32'(mem[8'hEF]), 32'h0);
        i_err_clear = 1'b1;
        @(posedge i_clk); #1;
        i_err_clear = 1'b0;
        chk("ovf_cleared", 32'(o_overflow), 32'h0);
        do_cmd(CALL, 16'h0, 16'h1111, 1'b1, wl, wa, wd, rd, rr);
        chk("ovf_set_wins", 32'(o_overflow), 32'h1);

        // Reset asserted while a POP waits on RAM: the response is dropped
        do_reset();
        do_cmd(PUSH, 16'hAAAA, 16'h0, 1'b0, wl, wa, wd, rd, rr);
        i_cmd_valid = 1'b1; i_cmd_op = POP;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("rstpop_sp", 32'(o_sp), 32'h00FF);
        chk("rstpop_valid", 32'(o_rsp_valid), 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("rstpop_ready", 32'(o_cmd_ready), 32'h1);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (o_rsp_valid) ok = 1'b0;
            @(posedge i_clk); #1;
        end
        chk("rstpop_no_rsp", 32'(ok), 32'h1);

        // SP load blocks a simultaneous command and overwrites SP
        i_sp_load = 1'b1; i_sp_value = 8'h80;
        i_cmd_valid = 1'b1; i_cmd_op = PUSH; i_cmd_data = 16'h5555;
        #2;
        chk("spload_ready", 32'(o_cmd_ready), 32'h0);
        chk("spload_no_write", 32'(o_ram_load), 32'h0);
        @(posedge i_clk); #1;
        i_sp_load = 1'b0; i_cmd_valid = 1'b0;
        chk("spload_sp", 32'(o_sp), 32'h0080);
        chk("spload_depth", 32'(o_depth), 32'h007F);
        chk("spload_mem", 32'(mem[8'h80]), 32'h0);

        // Random traffic against a queue model of the stack
        do_reset();
        ovf_m = 1'b0; unf_m = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  op;
            logic [15:0] d, pc, exp_rd;
            logic        clr, err;
            int unsigned r;
            r = $urandom_range(0, 3);
            if ((i < 150) == (r < 3)) op = ($urandom_range(0, 1) == 1) ? PUSH : CALL;
            else                      op = ($urandom_range(0, 1) == 1) ? POP : RET;
            d   = 16'($urandom);
            pc  = 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            err = 1'b0;
            exp_rd = '0;
            if (!op[0]) begin
                if (q.size() >= CAP) err = 1'b1;
                do_cmd(op, d, pc, clr, wl, wa, wd, rd, rr);
                chk("rnd_wload", 32'(wl), 32'(!err));
                if (!err) begin
                    chk("rnd_waddr", 32'(wa), 32'(8'hFF - 8'(q.size())));
                    chk("rnd_wdata", 32'(wd), 32'(op[1] ? pc : d));
                    q.push_back(op[1] ? pc : d);
                end
                ovf_m = err | (ovf_m & !clr);
                unf_m = unf_m & !clr;
            end else begin
                if (q.size() == 0) err = 1'b1;
                else exp_rd = q.pop_back();
                do_cmd(op, d, pc, clr, wl, wa, wd, rd, rr);
                chk("rnd_rdata", 32'(rd), 32'(exp_rd));
                chk("rnd_is_ret", 32'(rr), 32'(op[1]));
                unf_m = err | (unf_m & !clr);
                ovf_m = ovf_m & !clr;
            end
            chk("rnd_sp", 32'(o_sp), 32'(8'hFF - 8'(q.size())));
            chk("rnd_depth", 32'(o_depth), 32'(q.size()));
            chk("rnd_ovf", 32'(o_overflow), 32'(ovf_m));
            chk("rnd_unf", 32'(o_underflow), 32'(unf_m));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised hardware stack unit that takes over PUSH/POP/CALL/RET sequencing and SP ownership from the core's inline stack logic.
- Sits between the core's execute FSM and the data RAM, which has a synchronous write and a registered read (data is valid one clock after the address).
- Adds what the inline logic lacks: a valid/ready command handshake, configurable width, depth and stack bounds, sticky overflow/underflow detection, a depth readout and a direct SP write port.

Parameters:
- DATA_WIDTH, 16, width of stacked words and of the return PC.
- ADDR_WIDTH, 8, RAM address width; SP is held at this width.
- STACK_BASE, 8'hFF, SP value at reset and when the stack is empty. The stack grows downward.
- STACK_LIMIT, 8'hF0, lowest writable SP. Must be strictly less than STACK_BASE. Capacity is STACK_BASE-STACK_LIMIT+1 words.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  engine accepts a command this cycle
- i_cmd_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- i_cmd_data  in  DATA_WIDTH  PUSH value
- i_ret_pc  in  DATA_WIDTH  return address stored by CALL
- i_sp_load  in  1  overwrite SP
- i_sp_value  in  ADDR_WIDTH  new SP value
- i_err_clear  in  1  clear sticky error flags
- o_rsp_valid  out  1  one-cycle pulse; POP or RET result is valid
- o_rsp_is_ret  out  1  qualifies o_rsp_valid; 1 means o_rsp_data is a PC to load
- o_rsp_data  out  DATA_WIDTH  popped word
- o_ram_load  out  1  RAM write enable
- o_ram_addr  out  ADDR_WIDTH  RAM address
- o_ram_data  out  DATA_WIDTH  RAM write data
- i_ram_data  in  DATA_WIDTH  RAM read data (registered, 1-cycle latency)
- o_sp  out  ADDR_WIDTH  current SP
- o_depth  out  ADDR_WIDTH  STACK_BASE-SP
- o_overflow  out  1  sticky flag
- o_underflow  out  1  sticky flag

Behaviour:
- Reset (asynchronous, any state, including mid-POP):
  - SP=STACK_BASE, state IDLE.
  - o_rsp_valid, o_rsp_is_ret, o_rsp_data, o_ram_load, o_overflow, o_underflow all 0.
  - An in-flight read is discarded; no response is produced.
- States: IDLE, RD_WAIT, RD_DONE.
- o_cmd_ready = (state==IDLE) && !i_sp_load.
- A command is accepted when i_cmd_valid && o_cmd_ready.
- PUSH/CALL, accepted at cycle T:
  - Same cycle: o_ram_load=1, o_ram_addr=SP, o_ram_data = i_cmd_data (PUSH) or i_ret_pc (CALL).
  - SP<=SP-1 at the end of T.
  - State stays IDLE, so back-to-back pushes run at 1 per clock.
- PUSH/CALL when SP<STACK_LIMIT (stack full):
  - No write, SP unchanged, o_overflow<=1.
  - The command is still consumed.
- POP/RET, accepted at cycle T:
  - o_ram_addr=SP+1 (wraps modulo 2^ADDR_WIDTH), o_ram_load=0, SP<=SP+1.
  - Go to RD_WAIT.
  - T+1: RD_WAIT registers i_ram_data into o_rsp_data and goes to RD_DONE.
  - T+2: RD_DONE asserts o_rsp_valid=1 for one cycle, with o_rsp_is_ret=1 for RET.
  - T+3: back in IDLE; ready again. POP/RET occupancy is 3 cycles.
- POP/RET when SP==STACK_BASE (stack empty):
  - SP unchanged, o_underflow<=1.
  - The FSM still runs RD_WAIT→RD_DONE; o_rsp_data=0 and o_rsp_valid pulses at T+2, so the core never hangs.
- i_sp_load:
  - Honoured in any state; SP<=i_sp_value at the clock edge.
  - It forces o_cmd_ready low, so it never coincides with an accepted command.
  - In RD_WAIT/RD_DONE the pending read completes unaffected; its address was already issued.
- o_ram_addr and o_ram_data are don't-care when no command is being accepted. o_ram_load is 0 outside an accepted PUSH/CALL.
- Sticky flags:
  - i_err_clear clears both flags on the next edge.
  - If a new error occurs in the same cycle as the clear, set wins.
- o_depth = STACK_BASE-SP, ADDR_WIDTH wide, combinational from the SP register.
- The engine never writes above STACK_BASE or below STACK_LIMIT. The exception is SP set by i_sp_load to a value outside the bounds: bounds checks compare against SP as-is, and no correction is applied.

Test Plan:
- Reset, then PUSH 0x1234 and PUSH 0xBEEF on consecutive clocks -> RAM[0xFF]=0x1234, RAM[0xFE]=0xBEEF, o_sp=0xFD, o_depth=2, ready high throughout.
- Continuing from above, POP -> o_rsp_valid pulses exactly 2 cycles after acceptance with o_rsp_data=0xBEEF and o_rsp_is_ret=0; o_sp=0xFE; ready low for 2 cycles.
- CALL with i_ret_pc=0x0042, then RET -> RAM[SP] written with 0x0042; RET response has o_rsp_is_ret=1, o_rsp_data=0x0042; SP restored.
- 16 PUSHes from reset (fills 0xFF..0xF0), then a 17th PUSH -> no write on the 17th, o_sp=0xEF, o_overflow=1. Assert i_err_clear -> o_overflow=0.
- POP on an empty stack -> o_underflow=1, o_sp=0xFF, o_rsp_valid pulses with o_rsp_data=0.
- Assert i_rst during RD_WAIT of a POP -> no o_rsp_valid, o_sp=0xFF, ready high on the first cycle after reset deasserts. Separately, i_sp_load=1 with i_cmd_valid=1 -> command not accepted, o_sp=i_sp_value.
